// File: rtl/bitnet_pkg.sv
// Shared types and width helpers for the BitNet weight-flip datapath.
package bitnet_pkg;

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} flip_state_t;

  localparam int RD_LAT_DEFAULT = 2;

  // A single lane still needs one index bit so that ports never collapse to zero width.
  function automatic int lane_width(input int n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

  function automatic int addr_width(input int row_w, input int n_lanes);
    return row_w + lane_width(n_lanes);
  endfunction

endpackage

// File: rtl/flip_writer_if.sv
// Trigger, BRAM and status signals between the accumulator row, flip_writer and weight memory.
interface flip_writer_if #(
  parameter int N_LANES = 16,
  parameter int ROW_W   = 8,
  parameter int CNT_W   = 32
);
  import bitnet_pkg::*;

  localparam int ADDR_W = addr_width(ROW_W, N_LANES);

  logic               trig_valid_in;
  logic [N_LANES-1:0] trig_in;
  logic [ROW_W-1:0]   row_in;
  logic               trig_ready_out;
  logic               rd_en_out;
  logic [ADDR_W-1:0]  rd_addr_out;
  logic               rd_data_in;
  logic               wr_en_out;
  logic [ADDR_W-1:0]  wr_addr_out;
  logic               wr_data_out;
  logic               done_out;
  logic [CNT_W-1:0]   flip_count_out;

  modport master (
    output trig_valid_in, trig_in, row_in, rd_data_in,
    input  trig_ready_out, rd_en_out, rd_addr_out, wr_en_out, wr_addr_out,
    input  wr_data_out, done_out, flip_count_out
  );

  modport slave (
    input  trig_valid_in, trig_in, row_in, rd_data_in,
    output trig_ready_out, rd_en_out, rd_addr_out, wr_en_out, wr_addr_out,
    output wr_data_out, done_out, flip_count_out
  );

endinterface

// File: rtl/lowest_set_idx.sv
// Fixed-priority encoder: index of the lowest set bit, plus a flag that any bit is set.
module lowest_set_idx #(
  parameter int W     = 16,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flip_writer.sv
// Drains a captured trigger vector into read-modify-write sign flips of 1-bit weights,
// one lane at a time in ascending lane order.
module flip_writer
  import bitnet_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int ROW_W   = 8,
  parameter int RD_LAT  = RD_LAT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  flip_writer_if.slave bus
);

  localparam int LANE_W = lane_width(N_LANES);
  localparam int ADDR_W = ROW_W + LANE_W;
  localparam int WAIT_W = $clog2(RD_LAT + 1);

  flip_state_t        state, state_nx;
  logic [N_LANES-1:0] pending;
  logic [N_LANES-1:0] lane_mask;
  logic [N_LANES-1:0] remaining;
  logic [ROW_W-1:0]   row;
  logic [LANE_W-1:0]  lane_sel;
  logic [LANE_W-1:0]  lane;
  logic               any_set;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic               wr_data_q;
  logic               ready_q;
  logic [CNT_W-1:0]   flip_count;
  logic               capture;

  lowest_set_idx #(.W(N_LANES), .IDX_W(LANE_W)) u_lowest (
    .vec (pending),
    .idx (lane_sel),
    .any (any_set)
  );

  assign capture   = bus.trig_valid_in && ready_q;
  assign lane_mask = {{(N_LANES-1){1'b0}}, 1'b1} << lane;
  assign remaining = pending & ~lane_mask;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture && (bus.trig_in != '0)) state_nx = READ;
      READ:    state_nx = any_set ? WAIT : IDLE;
      WAIT:    if (wait_cnt == WAIT_W'(1)) state_nx = WRITE;
      WRITE:   state_nx = (remaining != '0) ? READ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      pending    <= '0;
      row        <= '0;
      lane       <= '0;
      wait_cnt   <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= 1'b0;
      flip_count <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (capture) begin
            pending <= bus.trig_in;
            row     <= bus.row_in;
          end
        end
        READ: begin
          lane      <= lane_sel;
          rd_addr_q <= {row, lane_sel};
          wait_cnt  <= WAIT_W'(RD_LAT);
        end
        WAIT: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          // Last wait cycle is exactly when the BRAM presents the read word.
          if (wait_cnt == WAIT_W'(1)) begin
            wr_addr_q <= {row, lane};
            wr_data_q <= ~bus.rd_data_in;
          end
        end
        WRITE: begin
          pending <= remaining;
          if (flip_count != {CNT_W{1'b1}}) flip_count <= flip_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Read address is live during READ so the lane choice costs no extra cycle.
  assign bus.trig_ready_out = ready_q;
  assign bus.rd_en_out      = (state == READ);
  assign bus.rd_addr_out    = (state == READ) ? {row, lane_sel} : rd_addr_q;
  assign bus.wr_en_out      = (state == WRITE);
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign bus.done_out       = (state == WRITE) && (remaining == '0);
  assign bus.flip_count_out = flip_count;

endmodule

// File: tb/tb_flip_writer.sv
// Bench for flip_writer: BRAM model, event monitor and a lane-by-lane reference of expected flips.
module tb_flip_writer;
  localparam int N_LANES = 16;
  localparam int ROW_W   = 8;
  localparam int RD_LAT  = 2;
  localparam int CNT_W   = 2;
  localparam int ADDR_W  = 12;
  localparam int CNT_MAX = 3;
  localparam int MEM_N   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flip_writer_if #(.N_LANES(N_LANES), .ROW_W(ROW_W), .CNT_W(CNT_W)) bus ();

  flip_writer #(.N_LANES(N_LANES), .ROW_W(ROW_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  function automatic logic init_bit(input int a);
    logic [31:0] h;
    if (a == 12'h000) return 1'b1;
    if (a == 12'h035 || a == 12'h00F) return 1'b0;
    h = 32'(a) * 32'd2654435761;
    return h[17];
  endfunction

  // BRAM model: read word appears RD_LAT cycles after the strobe, garbage otherwise.
  logic mem [0:MEM_N-1];
  logic mem_loaded = 1'b0;
  logic rd_d1, rd_d2;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < MEM_N; a++) mem[a] <= init_bit(a);
      mem_loaded <= 1'b1;
    end else if (bus.wr_en_out) begin
      mem[bus.wr_addr_out] <= bus.wr_data_out;
    end
    rd_d1 <= bus.rd_en_out ? mem[bus.rd_addr_out] : 1'($urandom);
    rd_d2 <= rd_d1;
  end
  assign bus.rd_data_in = rd_d2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; bit wr; logic [ADDR_W-1:0] addr; logic data;} ev_t;
  ev_t got_q[$];
  int  got_done[$];
  int  overlap = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en_out) got_q.push_back('{cyc, 1'b0, bus.rd_addr_out, 1'b0});
      if (bus.wr_en_out) got_q.push_back('{cyc, 1'b1, bus.wr_addr_out, bus.wr_data_out});
      if (bus.done_out) got_done.push_back(cyc);
      if (bus.rd_en_out && bus.wr_en_out) overlap = overlap + 1;
    end
  end

  logic ref_mem [0:MEM_N-1];
  ev_t  exp_q[$];
  int   exp_done[$];
  int   got_rd = 0, done_rd = 0;
  int   model_cnt = 0;
  int   checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: flip each requested lane in ascending order, RD_LAT+2 cycles per flip.
  task automatic build(input logic [15:0] t, input logic [7:0] r, input int cap,
                       input int nmax, output int k);
    logic [ADDR_W-1:0] a;
    bit truncated;
    k = 0;
    truncated = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (t[i]) begin
        a = {r, 4'(i)};
        if (k < nmax) begin
          exp_q.push_back('{cap + (RD_LAT + 2) * k, 1'b0, a, 1'b0});
          ref_mem[a] = ~ref_mem[a];
          exp_q.push_back('{cap + (RD_LAT + 2) * k + RD_LAT + 1, 1'b1, a, ref_mem[a]});
          k++;
        end else if (!truncated) begin
          exp_q.push_back('{cap + (RD_LAT + 2) * k, 1'b0, a, 1'b0});
          truncated = 1'b1;
        end
      end
    end
    if (k > 0 && !truncated) exp_done.push_back(cap + (RD_LAT + 2) * k - 1);
    model_cnt = (model_cnt + k > CNT_MAX) ? CNT_MAX : model_cnt + k;
  endtask

  task automatic compare_events(input string tag);
    int n, avail;
    ev_t g, e;
    n = exp_q.size();
    avail = got_q.size() - got_rd;
    check({tag, "_nevents"}, 64'(avail), 64'(n));
    for (int i = 0; i < n && i < avail; i++) begin
      g = got_q[got_rd + i];
      e = exp_q[i];
      check({tag, "_event"}, {g.cyc, g.wr, g.addr, g.data}, {e.cyc, e.wr, e.addr, e.data});
    end
    got_rd += avail;
    exp_q.delete();
    n = exp_done.size();
    avail = got_done.size() - done_rd;
    check({tag, "_ndone"}, 64'(avail), 64'(n));
    for (int i = 0; i < n && i < avail; i++)
      check({tag, "_done_cyc"}, 64'(got_done[done_rd + i]), 64'(exp_done[i]));
    done_rd += avail;
    exp_done.delete();
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (bus.trig_ready_out !== 1'b1 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (bus.trig_ready_out !== 1'b1) check({tag, "_ready_timeout"}, bus.trig_ready_out, 1);
  endtask

  task automatic send(input logic [15:0] t, input logic [7:0] r, output int cap);
    wait_ready("send");
    bus.trig_valid_in = 1'b1;
    bus.trig_in = t;
    bus.row_in = r;
    @(posedge clk);
    #1;
    cap = cyc;
    bus.trig_valid_in = 1'b0;
    bus.trig_in = 16'($urandom);
    bus.row_in = 8'($urandom);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] t, input logic [7:0] r, output int k);
    int cap;
    send(t, r, cap);
    build(t, r, cap, N_LANES, k);
    wait_cycles((RD_LAT + 2) * k + 3);
    compare_events(tag);
    check({tag, "_count"}, bus.flip_count_out, model_cnt);
    check({tag, "_ready_after"}, bus.trig_ready_out, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, bus.trig_ready_out, 0);
    check({tag, "_rd_en"}, bus.rd_en_out, 0);
    check({tag, "_wr_en"}, bus.wr_en_out, 0);
    check({tag, "_done"}, bus.done_out, 0);
    check({tag, "_count"}, bus.flip_count_out, 0);
    check({tag, "_addrs"}, {bus.rd_addr_out, bus.wr_addr_out, bus.wr_data_out}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset");
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    model_cnt = 0;
  endtask

  typedef struct {logic [15:0] trig; logic [7:0] row; int n_wr; int cnt;} vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   sat_exp[5];
    int   k, cap_a, cap_b, k_a, k_b, low, g, diffs;
    logic [15:0] t;

    tbl[0] = '{16'h0020, 8'd3, 1, 1};
    tbl[1] = '{16'h8001, 8'd0, 2, 3};
    tbl[2] = '{16'h0000, 8'd5, 0, 3};
    tbl[3] = '{16'h0A00, 8'hFF, 2, 3};
    sat_exp = '{1, 2, 3, 3, 3};

    for (int a = 0; a < MEM_N; a++) ref_mem[a] = init_bit(a);
    bus.trig_valid_in = 1'b0;
    bus.trig_in = '0;
    bus.row_in = '0;
    wait_cycles(3);
    do_reset();
    check("ready_post_reset", bus.trig_ready_out, 1);

    // Directed table: single flip, two lanes, empty vector, top row.
    for (int i = 0; i < 4; i++) begin
      run_vec("tbl", tbl[i].trig, tbl[i].row, k);
      check("tbl_nflips", 64'(k), 64'(tbl[i].n_wr));
      check("tbl_count_abs", bus.flip_count_out, 64'(tbl[i].cnt));
      if (tbl[i].n_wr == 0) begin
        for (int c = 0; c < 4; c++) begin
          check("empty_ready_held", bus.trig_ready_out, 1);
          wait_cycles(1);
        end
        compare_events("empty_quiet");
      end
    end

    // Saturation with a 2-bit counter.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      run_vec("sat", 16'(1) << ((j * 3) % 16), 8'(j + 20), k);
      check("sat_count", bus.flip_count_out, 64'(sat_exp[j]));
    end

    // Backpressure: second vector held valid through the whole drain.
    do_reset();
    wait_ready("bp");
    bus.trig_valid_in = 1'b1;
    bus.trig_in = 16'h0111;
    bus.row_in = 8'd7;
    @(posedge clk);
    #1;
    cap_a = cyc;
    bus.trig_in = 16'h8400;
    bus.row_in = 8'd9;
    build(16'h0111, 8'd7, cap_a, N_LANES, k_a);
    low = 0;
    g = 0;
    while (bus.trig_ready_out !== 1'b1 && g < 200) begin
      low++;
      @(posedge clk);
      #1;
      g++;
    end
    check("bp_ready_low_cycles", 64'(low), 64'((RD_LAT + 2) * k_a));
    @(posedge clk);
    #1;
    cap_b = cyc;
    bus.trig_valid_in = 1'b0;
    check("bp_capture_cyc", 64'(cap_b), 64'(cap_a + (RD_LAT + 2) * k_a + 1));
    build(16'h8400, 8'd9, cap_a + (RD_LAT + 2) * k_a + 1, N_LANES, k_b);
    wait_cycles((RD_LAT + 2) * k_b + 3);
    compare_events("bp");
    check("bp_count", bus.flip_count_out, model_cnt);

    // Asynchronous reset while lane 2 waits for its read data.
    do_reset();
    send(16'hFFFF, 8'h42, cap_a);
    build(16'hFFFF, 8'h42, cap_a, 2, k);
    wait_cycles(2 * (RD_LAT + 2) + 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    wait_cycles(2);
    rst_n = 1'b1;
    model_cnt = 0;
    wait_cycles(20);
    compare_events("midreset");
    check("midreset_count", bus.flip_count_out, 0);

    // Randomized vectors against the reference.
    for (int i = 0; i < 40; i++) begin
      wait_cycles($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       t = 16'h0000;
        1:       t = 16'(1) << $urandom_range(0, 15);
        default: t = 16'($urandom) & 16'($urandom);
      endcase
      run_vec("rand", t, 8'($urandom), k);
    end

    check("strobe_overlap", 64'(overlap), 0);
    diffs = 0;
    for (int a = 0; a < MEM_N; a++) if (mem[a] !== ref_mem[a]) diffs++;
    check("mem_image", 64'(diffs), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
